dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences every access to the shared data SRAM, between the MEM stage and the SRAM port.
//  Two requesters share the SRAM: the pipeline load/store path (cpu) and a debug/fill port (dbg).
//  Builds byte enables, lane-shifts write data and sign/zero-extends load data.
//  Raises stall_req so the stall controller freezes EX/MEM while an access is in flight.
// PARAMETERS
//  RD_LAT       1  cycles from SRAM en to valid rdata (1..7)
//  STARVE_MAX   4  consecutive cpu grants while dbg waits before dbg is forced a grant (1..15)
// PORTS
//  clk             in   1   clock, rising edge
//  resetn          in   1   synchronous reset, active-low
//  cpu_req         in   1   pipeline request; held until cpu_done
//  cpu_we          in   1   1=store, 0=load
//  cpu_size        in   2   00=byte 01=half 10=word (11 treated as word)
//  cpu_sign        in   1   load sign-extend (1) / zero-extend (0)
//  cpu_addr        in   32  byte address
//  cpu_wdata       in   32  store data, right-aligned
//  cpu_rdata       out  32  extended load data, valid with cpu_done
//  cpu_done        out  1   one-cycle completion pulse
//  stall_req       out  1   pipeline stall request
//  dbg_req         in   1   debug request; held until dbg_done
//  dbg_we          in   1   debug write (always word, wen=4'b1111)
//  dbg_addr        in   32  word address (bits [1:0] ignored)
//  dbg_wdata       in   32  debug write data
//  dbg_rdata       out  32  raw read word, valid with dbg_done
//  dbg_done        out  1   one-cycle completion pulse
//  data_sram_en    out  1   SRAM enable, exactly one cycle per access
//  data_sram_wen   out  4   byte write enables (0 = read)
//  data_sram_addr  out  32  word-aligned address ({addr[31:2],2'b00})
//  data_sram_wdata out  32  lane-shifted write data
//  data_sram_rdata in   32  SRAM read data
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): state=IDLE, all outputs 0, starve counter 0, owner=cpu.
//  FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE: if any req, grant per arbitration, latch req fields, go ISSUE.
//   ISSUE: data_sram_en=1 one cycle with latched addr/wen/wdata; lat counter=RD_LAT-1; go WAIT (or DONE if RD_LAT=1).
//   WAIT: decrement lat counter; at 0 go DONE. SRAM outputs 0 here.
//   DONE: capture data_sram_rdata, pulse owner's done for one cycle; go IDLE.
//  Latency: req in IDLE -> done asserted RD_LAT+2 cycles later; stores take the same path (no early done).
//  Back-to-back: a req still high in the cycle after done is a NEW access (requester must drop req on done).
//  Arbitration (in IDLE only, never preempts): cpu wins over dbg unless starve count == STARVE_MAX.
//   starve count ++ on each cpu grant while dbg_req=1; cleared on dbg grant or when dbg_req=0; saturates.
//  stall_req = cpu_req & ~(cpu_done); i.e. high from the cpu_req cycle through the cycle before cpu_done,
//   including while dbg owns the SRAM; low in the cpu_done cycle.
//  Byte enables (cpu): byte: 4'b0001<<addr[1:0]; half: 4'b0011<<{addr[1],1'b0}; word: 4'b1111.
//  Write data: byte replicated x4, half replicated x2, word as-is.
//  Load data: select lane by addr[1:0]/addr[1], extend per cpu_sign to 32 bits.
//  Misaligned cpu access (half with addr[0]=1, word with addr[1:0]!=0): see CONFIGURATION.
//  Fields are latched at grant; changes to cpu_*/dbg_* inputs mid-access are ignored.
//  resetn low mid-access: abort immediately, no done pulse, SRAM en/wen forced 0 next cycle.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined: extra output misalign_exc (1 bit, reset 0). Misaligned cpu access
//   skips ISSUE/WAIT, goes straight to DONE; misalign_exc=1 with cpu_done; no SRAM enable; cpu_rdata=0.
//  Not defined: port absent; address low bits are forced to natural alignment
//   (half: addr[0]=0, word: addr[1:0]=0) and the access proceeds normally.
// TESTING
//  RD_LAT=1, cpu lw addr 0x10, SRAM word 0xDEADBEEF -> en 1 cycle, wen 0, addr 0x10; cpu_done 3 cycles after req, rdata 0xDEADBEEF.
//  cpu sb addr 0x13 wdata 0x000000A5 -> wen 4'b1000, sram_wdata 0xA5A5A5A5, addr 0x10; lb sign=1 back -> 0xFFFFFFA5, lbu -> 0x000000A5.
//  cpu lh addr 0x2 sign=1, word 0x80010000 -> rdata 0xFFFF8001; RD_LAT=3 -> cpu_done 5 cycles after req, stall_req high 5 cycles.
//  cpu_req and dbg_req held high continuously, STARVE_MAX=4 -> grants cpu,cpu,cpu,cpu,dbg,cpu,... ; dbg never waits >4 accesses.
//  resetn low during WAIT -> no done pulse, outputs 0 next cycle, next req after release completes normally.
//  With DMEM_MISALIGN_TRAP_EN: cpu lw addr 0x6 -> no data_sram_en, cpu_done+misalign_exc 1 cycle; without: access at 0x4.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Sequences every access to the shared data SRAM for two requesters: the
// pipeline load/store path (cpu) and a debug/fill port (dbg). Builds byte
// enables, lane-replicates store data, extends load data and raises stall_req
// while a cpu access is outstanding.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN adds misalign_exc and traps
// misaligned cpu accesses. Without it, misaligned addresses are forced to
// natural alignment and the access proceeds normally.

module dmem_access_ctrl #(
  parameter int RD_LAT     = 1,  // cycles from SRAM en to valid rdata (1..7)
  parameter int STARVE_MAX = 4   // cpu grants while dbg waits before dbg is forced (1..15)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sign,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        stall_req,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_done,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_exc
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LP_LAT_INIT   = 3'(RD_LAT - 1);
  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  state_t      r_state;
  state_t      w_state_nxt;

  // Access fields latched at grant; later input changes are ignored.
  logic        r_owner_dbg;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [1:0]  r_lane;
  logic [31:0] r_addr;
  logic [3:0]  r_wen;
  logic [31:0] r_wdata;
  logic        r_trap;

  logic [2:0]  r_lat_cnt;
  logic [3:0]  r_starve;
  logic        r_cpu_done;
  logic        r_dbg_done;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_dbg_rdata;

  logic        w_arb_ok;
  logic        w_grant_cpu;
  logic        w_grant_dbg;
  logic        w_trap;
  logic        w_issue;
  logic [1:0]  w_cpu_size;
  logic [1:0]  w_cpu_lane;
  logic [3:0]  w_cpu_wen;
  logic [31:0] w_cpu_wdata;
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic [31:0] w_load_ext;
  logic        w_unused_dbg_addr;

  // Debug addresses are word addresses; the byte offset is deliberately dropped.
  assign w_unused_dbg_addr = &{1'b0, dbg_addr[1:0]};

  // Arbitration only happens in IDLE, and not in the cycle a done pulse is out:
  // a request still held in that cycle belongs to the access just finished.
  assign w_arb_ok    = (r_state == S_IDLE) & ~r_cpu_done & ~r_dbg_done;
  assign w_grant_dbg = w_arb_ok & dbg_req & (~cpu_req | (r_starve == LP_STARVE_MAX));
  assign w_grant_cpu = w_arb_ok & cpu_req & ~w_grant_dbg;

  assign w_cpu_size  = (cpu_size == 2'b11) ? 2'b10 : cpu_size;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_trap = ((w_cpu_size == 2'b01) & cpu_addr[0]) |
                  ((w_cpu_size == 2'b10) & (cpu_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Decode the cpu request: lane, byte enables and replicated store data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    w_cpu_lane  = 2'b00;
    w_cpu_wen   = 4'b0000;
    w_cpu_wdata = cpu_wdata;
    case (w_cpu_size)
      2'b00: begin
        w_cpu_lane  = cpu_addr[1:0];
        w_cpu_wen   = 4'b0001 << cpu_addr[1:0];
        w_cpu_wdata = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        w_cpu_lane  = {cpu_addr[1], 1'b0};
        w_cpu_wen   = 4'b0011 << {cpu_addr[1], 1'b0};
        w_cpu_wdata = {2{cpu_wdata[15:0]}};
      end
      default: begin
        w_cpu_lane  = 2'b00;
        w_cpu_wen   = 4'b1111;
        w_cpu_wdata = cpu_wdata;
      end
    endcase
    if (!cpu_we) begin
      w_cpu_wen = 4'b0000;
    end
  end

  // Select the loaded lane from the SRAM word and extend it to 32 bits.
  always_comb begin
    case (r_lane)
      2'd1:    w_rd_byte = data_sram_rdata[15:8];
      2'd2:    w_rd_byte = data_sram_rdata[23:16];
      2'd3:    w_rd_byte = data_sram_rdata[31:24];
      default: w_rd_byte = data_sram_rdata[7:0];
    endcase
    w_rd_half = r_lane[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    case (r_size)
      2'b00:   w_load_ext = {{24{r_sign & w_rd_byte[7]}}, w_rd_byte};
      2'b01:   w_load_ext = {{16{r_sign & w_rd_half[15]}}, w_rd_half};
      default: w_load_ext = data_sram_rdata;
    endcase
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_cpu & w_trap) begin
          w_state_nxt = S_DONE;
        end else if (w_grant_cpu | w_grant_dbg) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = (RD_LAT == 1) ? S_DONE : S_WAIT;
      S_WAIT:  if (r_lat_cnt <= 3'd1) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block and clk is the only sensitivity.
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch request fields at grant, run the latency counter, capture read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_owner_dbg <= 1'b0;
      r_size      <= 2'b00;
      r_sign      <= 1'b0;
      r_lane      <= 2'b00;
      r_addr      <= 32'd0;
      r_wen       <= 4'b0000;
      r_wdata     <= 32'd0;
      r_trap      <= 1'b0;
      r_lat_cnt   <= 3'd0;
      r_cpu_done  <= 1'b0;
      r_dbg_done  <= 1'b0;
      r_cpu_rdata <= 32'd0;
      r_dbg_rdata <= 32'd0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      r_cpu_done <= 1'b0;
      r_dbg_done <= 1'b0;

      if (w_grant_dbg) begin
        r_owner_dbg <= 1'b1;
        r_size      <= 2'b10;
        r_sign      <= 1'b0;
        r_lane      <= 2'b00;
        r_addr      <= {dbg_addr[31:2], 2'b00};
        r_wen       <= dbg_we ? 4'b1111 : 4'b0000;
        r_wdata     <= dbg_wdata;
        r_trap      <= 1'b0;
      end else if (w_grant_cpu) begin
        r_owner_dbg <= 1'b0;
        r_size      <= w_cpu_size;
        r_sign      <= cpu_sign;
        r_lane      <= w_cpu_lane;
        r_addr      <= {cpu_addr[31:2], 2'b00};
        r_wen       <= w_cpu_wen;
        r_wdata     <= w_cpu_wdata;
        r_trap      <= w_trap;
      end

      if (r_state == S_ISSUE) begin
        r_lat_cnt <= LP_LAT_INIT;
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt - 3'd1;
      end

      if (r_state == S_DONE) begin
        if (r_owner_dbg) begin
          r_dbg_rdata <= data_sram_rdata;
          r_dbg_done  <= 1'b1;
        end else begin
          r_cpu_rdata <= r_trap ? 32'd0 : w_load_ext;
          r_cpu_done  <= 1'b1;
        end
      end
    end
  end

  // Count cpu grants made while dbg waits; saturates, cleared when dbg is served or idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve <= 4'd0;
    end else if (!dbg_req || w_grant_dbg) begin
      r_starve <= 4'd0;
    end else if (w_grant_cpu && (r_starve != LP_STARVE_MAX)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_misalign_exc;

  // Misalignment flag pulses together with the trapped access's cpu_done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_misalign_exc <= 1'b0;
    end else begin
      r_misalign_exc <= (r_state == S_DONE) & ~r_owner_dbg & r_trap;
    end
  end

  assign misalign_exc = r_misalign_exc;
`endif

  // The SRAM port is driven only during the single ISSUE cycle.
  assign w_issue         = (r_state == S_ISSUE);
  assign data_sram_en    = w_issue;
  assign data_sram_wen   = w_issue ? r_wen   : 4'b0000;
  assign data_sram_addr  = w_issue ? r_addr  : 32'd0;
  assign data_sram_wdata = w_issue ? r_wdata : 32'd0;

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_done  = r_cpu_done;
  assign dbg_rdata = r_dbg_rdata;
  assign dbg_done  = r_dbg_done;
  assign stall_req = cpu_req & ~r_cpu_done;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: one instance with RD_LAT=1 carries most
// scenarios, a second with RD_LAT=3 covers the longer latency and a reset
// abort during WAIT. Each instance has a small behavioural SRAM whose read
// data is only valid exactly RD_LAT cycles after the enable.

module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        cpu_req, cpu_req3, cpu_we, cpu_sign;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;

  logic [31:0] cpu_rdata1, dbg_rdata1, addr1, wdata1, rdata1;
  logic        cpu_done1, dbg_done1, stall1, en1;
  logic [3:0]  wen1;
  logic [31:0] cpu_rdata3, dbg_rdata3, addr3, wdata3, rdata3;
  logic        cpu_done3, dbg_done3, stall3, en3;
  logic [3:0]  wen3;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        exc1, exc3, last_exc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent access task.
  logic [31:0] got_rd, got_addr, got_wdata;
  logic [3:0]  got_wen;
  int          got_lat, got_stall, got_en;

  dmem_access_ctrl #(.RD_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1),
    .cpu_done(cpu_done1), .stall_req(stall1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata1), .dbg_done(dbg_done1),
    .data_sram_en(en1), .data_sram_wen(wen1), .data_sram_addr(addr1),
    .data_sram_wdata(wdata1), .data_sram_rdata(rdata1)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .misalign_exc(exc1)
`endif
  );

  dmem_access_ctrl #(.RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req3), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata3),
    .cpu_done(cpu_done3), .stall_req(stall3),
    .dbg_req(1'b0), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata3), .dbg_done(dbg_done3),
    .data_sram_en(en3), .data_sram_wen(wen3), .data_sram_addr(addr3),
    .data_sram_wdata(wdata3), .data_sram_rdata(rdata3)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .misalign_exc(exc3)
`endif
  );

  // Behavioural SRAMs; rdata carries a poison value outside its valid cycle.
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] p1, p2;

  always @(posedge clk) begin
    if (en1 && wen1 != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (wen1[b]) mem1[addr1[7:2]][8*b +: 8] = wdata1[8*b +: 8];
    end
    rdata1 <= (en1 && wen1 == 4'b0000) ? mem1[addr1[7:2]] : 32'hBAD0BAD0;
  end

  always @(posedge clk) begin
    p1     <= (en3 && wen3 == 4'b0000) ? mem3[addr3[7:2]] : 32'hBAD0BAD0;
    p2     <= p1;
    rdata3 <= p2;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One cpu access on the selected instance; req is dropped when done is seen.
  task automatic cpu_access(input bit use3, input logic we, input logic [1:0] size,
                            input logic sign, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    cpu_we = we; cpu_size = size; cpu_sign = sign; cpu_addr = addr; cpu_wdata = wdata;
    if (use3) cpu_req3 = 1'b1; else cpu_req = 1'b1;
    got_lat = -1; got_stall = 0; got_en = 0; got_rd = '0;
    got_wen = '0; got_addr = '0; got_wdata = '0;
    #1;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (use3 ? stall3 : stall1) got_stall++;
      if (use3 ? en3 : en1) begin
        got_en++;
        got_wen   = use3 ? wen3 : wen1;
        got_addr  = use3 ? addr3 : addr1;
        got_wdata = use3 ? wdata3 : wdata1;
      end
      if (use3 ? cpu_done3 : cpu_done1) begin
        got_lat = k;
        got_rd  = use3 ? cpu_rdata3 : cpu_rdata1;
`ifdef DMEM_MISALIGN_TRAP_EN
        last_exc = use3 ? exc3 : exc1;
`endif
        break;
      end
    end
    cpu_req = 1'b0; cpu_req3 = 1'b0;
    if (got_lat < 0) begin
      n_checks++; n_errors++;
      $display("FAIL cpu_timeout: no cpu_done within 20 cycles for addr %h", addr);
    end
  endtask

  // One debug access on the RD_LAT=1 instance.
  task automatic dbg_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    got_lat = -1; got_en = 0; got_rd = '0; got_wen = '0; got_addr = '0;
    #1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (en1) begin got_en++; got_wen = wen1; got_addr = addr1; end
      if (dbg_done1) begin got_lat = k; got_rd = dbg_rdata1; break; end
    end
    dbg_req = 1'b0;
    if (got_lat < 0) begin
      n_checks++; n_errors++;
      $display("FAIL dbg_timeout: no dbg_done within 20 cycles for addr %h", addr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; cpu_req = 1'b0; cpu_req3 = 1'b0; dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({en1, wen1, addr1, wdata1} !== 69'd0) begin
      n_errors++; $display("FAIL reset_sram: got en=%b wen=%b addr=%h wdata=%h, expected all 0", en1, wen1, addr1, wdata1);
    end
    n_checks++;
    if ({cpu_done1, dbg_done1, stall1} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags: got done/dbg_done/stall=%b, expected 000", {cpu_done1, dbg_done1, stall1});
    end
    n_checks++;
    if ({cpu_rdata1, dbg_rdata1} !== 64'd0) begin
      n_errors++; $display("FAIL reset_rdata: got cpu=%h dbg=%h, expected 0", cpu_rdata1, dbg_rdata1);
    end
    resetn = 1'b1;
  endtask

  task automatic test_cpu_load();
    mem1[4] = 32'hDEADBEEF;
    cpu_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    n_checks++; if (got_en !== 1) begin n_errors++; $display("FAIL lw_en_cycles: got %0d, expected 1", got_en); end
    n_checks++; if (got_wen !== 4'b0000) begin n_errors++; $display("FAIL lw_wen: got %b, expected 0000", got_wen); end
    n_checks++; if (got_addr !== 32'h10) begin n_errors++; $display("FAIL lw_addr: got %h, expected 00000010", got_addr); end
    n_checks++; if (got_lat !== 3) begin n_errors++; $display("FAIL lw_latency: got %0d, expected 3", got_lat); end
    n_checks++; if (got_stall !== 3) begin n_errors++; $display("FAIL lw_stall: got %0d, expected 3", got_stall); end
    n_checks++; if (got_rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_rdata: got %h, expected deadbeef", got_rd); end
  endtask

  task automatic test_store_byte();
    cpu_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
    n_checks++; if (got_wen !== 4'b1000) begin n_errors++; $display("FAIL sb_wen: got %b, expected 1000", got_wen); end
    n_checks++; if (got_wdata !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL sb_wdata: got %h, expected a5a5a5a5", got_wdata); end
    n_checks++; if (got_addr !== 32'h10) begin n_errors++; $display("FAIL sb_addr: got %h, expected 00000010", got_addr); end
    n_checks++; if (got_lat !== 3) begin n_errors++; $display("FAIL sb_latency: got %0d, expected 3", got_lat); end
    cpu_access(1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
    n_checks++; if (got_rd !== 32'hFFFFFFA5) begin n_errors++; $display("FAIL lb_rdata: got %h, expected ffffffa5", got_rd); end
    cpu_access(1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
    n_checks++; if (got_rd !== 32'h000000A5) begin n_errors++; $display("FAIL lbu_rdata: got %h, expected 000000a5", got_rd); end
  endtask

  task automatic test_half();
    mem1[0] = 32'h80010000;
    mem1[1] = 32'h11223344;
    cpu_access(1'b0, 1'b0, 2'b01, 1'b1, 32'h2, 32'd0);
    n_checks++; if (got_rd !== 32'hFFFF8001) begin n_errors++; $display("FAIL lh_rdata: got %h, expected ffff8001", got_rd); end
    cpu_access(1'b0, 1'b0, 2'b01, 1'b0, 32'h2, 32'd0);
    n_checks++; if (got_rd !== 32'h00008001) begin n_errors++; $display("FAIL lhu_rdata: got %h, expected 00008001", got_rd); end
    cpu_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h6, 32'h0000BEEF);
    n_checks++; if (got_wen !== 4'b1100) begin n_errors++; $display("FAIL sh_wen: got %b, expected 1100", got_wen); end
    n_checks++; if (got_wdata !== 32'hBEEFBEEF) begin n_errors++; $display("FAIL sh_wdata: got %h, expected beefbeef", got_wdata); end
    cpu_access(1'b0, 1'b0, 2'b01, 1'b1, 32'h6, 32'd0);
    n_checks++; if (got_rd !== 32'hFFFFBEEF) begin n_errors++; $display("FAIL lh_after_sh: got %h, expected ffffbeef", got_rd); end
  endtask

  task automatic test_back_to_back();
    mem1[2] = 32'h01020304;
    mem1[3] = 32'h05060708;
    cpu_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h8, 32'd0);
    n_checks++; if (got_rd !== 32'h01020304) begin n_errors++; $display("FAIL b2b_first_rdata: got %h, expected 01020304", got_rd); end
    cpu_access(1'b0, 1'b0, 2'b10, 1'b0, 32'hC, 32'd0);
    n_checks++; if (got_lat !== 3) begin n_errors++; $display("FAIL b2b_second_latency: got %0d, expected 3", got_lat); end
    n_checks++; if (got_rd !== 32'h05060708) begin n_errors++; $display("FAIL b2b_second_rdata: got %h, expected 05060708", got_rd); end
  endtask

  task automatic test_misalign();
    mem1[1] = 32'h11223344;
`ifdef DMEM_MISALIGN_TRAP_EN
    cpu_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
    n_checks++; if (got_en !== 0) begin n_errors++; $display("FAIL trap_en_cycles: got %0d, expected 0", got_en); end
    n_checks++; if (got_lat !== 2) begin n_errors++; $display("FAIL trap_latency: got %0d, expected 2", got_lat); end
    n_checks++; if (last_exc !== 1'b1) begin n_errors++; $display("FAIL trap_exc: got %b, expected 1", last_exc); end
    n_checks++; if (got_rd !== 32'd0) begin n_errors++; $display("FAIL trap_rdata: got %h, expected 00000000", got_rd); end
`else
    cpu_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
    n_checks++; if (got_addr !== 32'h4) begin n_errors++; $display("FAIL align_lw_addr: got %h, expected 00000004", got_addr); end
    n_checks++; if (got_rd !== 32'h11223344) begin n_errors++; $display("FAIL align_lw_rdata: got %h, expected 11223344", got_rd); end
    cpu_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h7, 32'h0000BEEF);
    n_checks++; if (got_wen !== 4'b1100) begin n_errors++; $display("FAIL align_sh_wen: got %b, expected 1100", got_wen); end
`endif
  endtask

  task automatic test_dbg();
    dbg_access(1'b1, 32'h23, 32'hCAFEF00D);
    n_checks++; if (got_wen !== 4'b1111) begin n_errors++; $display("FAIL dbg_wen: got %b, expected 1111", got_wen); end
    n_checks++; if (got_addr !== 32'h20) begin n_errors++; $display("FAIL dbg_addr: got %h, expected 00000020", got_addr); end
    n_checks++; if (got_lat !== 3) begin n_errors++; $display("FAIL dbg_latency: got %0d, expected 3", got_lat); end
    dbg_access(1'b0, 32'h20, 32'd0);
    n_checks++; if (got_rd !== 32'hCAFEF00D) begin n_errors++; $display("FAIL dbg_rdata: got %h, expected cafef00d", got_rd); end
  endtask

  task automatic test_arbitration();
    logic [9:0] seen_dbg;
    int         n_ev;
    bit         stall_done;
    seen_dbg = '0; n_ev = 0; stall_done = 1'b0;
    @(negedge clk);
    cpu_we = 1'b0; cpu_size = 2'b10; cpu_sign = 1'b0; cpu_addr = 32'h10;
    dbg_we = 1'b0; dbg_addr = 32'h20;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int k = 0; k < 80 && n_ev < 10; k++) begin
      @(negedge clk); #1;
      if (dbg_done1) begin
        seen_dbg[n_ev] = 1'b1;
        n_ev++;
        if (!stall_done) begin
          stall_done = 1'b1;
          n_checks++;
          if (stall1 !== 1'b1) begin n_errors++; $display("FAIL arb_stall_during_dbg: got %b, expected 1", stall1); end
        end
      end else if (cpu_done1) begin
        n_ev++;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    n_checks++; if (n_ev != 10) begin n_errors++; $display("FAIL arb_events: got %0d, expected 10", n_ev); end
    n_checks++; if (seen_dbg !== 10'b1000010000) begin n_errors++; $display("FAIL arb_order: got %b, expected 1000010000", seen_dbg); end
  endtask

  task automatic test_rd_lat3();
    mem3[0] = 32'h80010000;
    cpu_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'd0);
    n_checks++; if (got_lat !== 5) begin n_errors++; $display("FAIL lat3_latency: got %0d, expected 5", got_lat); end
    n_checks++; if (got_stall !== 5) begin n_errors++; $display("FAIL lat3_stall: got %0d, expected 5", got_stall); end
    n_checks++; if (got_en !== 1) begin n_errors++; $display("FAIL lat3_en_cycles: got %0d, expected 1", got_en); end
    n_checks++; if (got_rd !== 32'hFFFF8001) begin n_errors++; $display("FAIL lat3_rdata: got %h, expected ffff8001", got_rd); end
  endtask

  task automatic test_reset_mid();
    int n_done;
    mem3[0] = 32'h80010000;
    @(negedge clk);
    cpu_we = 1'b0; cpu_size = 2'b10; cpu_sign = 1'b0; cpu_addr = 32'h0; cpu_req3 = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (en3 !== 1'b1) begin n_errors++; $display("FAIL abort_issue_en: got %b, expected 1", en3); end
    @(negedge clk); #1;
    n_checks++; if (en3 !== 1'b0) begin n_errors++; $display("FAIL abort_wait_en: got %b, expected 0", en3); end
    resetn = 1'b0; cpu_req3 = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({en3, wen3, cpu_done3} !== 6'd0) begin
      n_errors++; $display("FAIL abort_outputs: got en=%b wen=%b done=%b, expected all 0", en3, wen3, cpu_done3);
    end
    resetn = 1'b1;
    n_done = 0;
    repeat (8) begin @(negedge clk); #1; if (cpu_done3) n_done++; end
    n_checks++; if (n_done != 0) begin n_errors++; $display("FAIL abort_no_done: got %0d pulses, expected 0", n_done); end
    cpu_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'd0);
    n_checks++; if (got_lat !== 5) begin n_errors++; $display("FAIL abort_recover_latency: got %0d, expected 5", got_lat); end
    n_checks++; if (got_rd !== 32'hFFFF8001) begin n_errors++; $display("FAIL abort_recover_rdata: got %h, expected ffff8001", got_rd); end
  endtask

  initial begin
    resetn = 1'b0; cpu_req = 1'b0; cpu_req3 = 1'b0; cpu_we = 1'b0; cpu_sign = 1'b0;
    cpu_size = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 64; i++) begin mem1[i] = '0; mem3[i] = '0; end

    test_reset();
    test_cpu_load();
    test_store_byte();
    test_half();
    test_back_to_back();
    test_misalign();
    test_dbg();
    test_arbitration();
    test_rd_lat3();
    test_reset_mid();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
